// File: rtl/insfetch_queue_pkg.sv
// Shared definitions for the instruction prefetch queue: widths, FSM
// encoding, queue entry layout and the JAL target helper used when the
// INSFQ_JAL_FOLLOW_EN build option is defined.
package insfetch_queue_pkg;

  localparam int INS_W   = 32;
  localparam int ENTRY_W = 64;

  localparam logic [6:0] OPCODE_JAL = 7'b1101111;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DRAIN = 2'd3
  } fsm_state_e;

  typedef struct packed {
    logic [INS_W-1:0] pc;
    logic [INS_W-1:0] ins;
  } fq_entry_t;

  // Static taken-jump target: PC + sign-extended J-type immediate.
  function automatic logic [INS_W-1:0] jal_target(input logic [INS_W-1:0] pc,
                                                  input logic [INS_W-1:0] ins);
    logic [INS_W-1:0] imm;
    imm = {{12{ins[31]}}, ins[19:12], ins[20], ins[30:21], 1'b0};
    return pc + imm;
  endfunction

endpackage

// File: rtl/insfetch_queue_store.sv
// insfq_store: DEPTH x 64-bit {PC, ins} register file, one write port and an
// asynchronous read of the queue head.
module insfq_store
  import insfetch_queue_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk_in,
  input  logic                     we_i,
  input  logic [$clog2(DEPTH)-1:0] waddr_i,
  input  fq_entry_t                wdata_i,
  input  logic [$clog2(DEPTH)-1:0] raddr_i,
  output fq_entry_t                rdata_o
);

  fq_entry_t mem_q [DEPTH];

  // Write the pushed entry into its slot.
  // NOTE: the storage array has no reset; occupancy is tracked by the count
  // and pointers in the parent, and the parent masks the head while empty.
  always_ff @(posedge clk_in) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/insfetch_queue.sv
// insfetch_queue: sequential instruction prefetch queue between MemAdapter
// and IssueManager. One fetch in flight at most; flush discards the queue
// and any in-flight word and redirects fetching.
// Build option: INSFQ_JAL_FOLLOW_EN -- follow JAL targets when prefetching.
module insfetch_queue
  import insfetch_queue_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic                   clk_in,
  input  logic                   rst_in,
  input  logic                   rdy_in,
  input  logic                   flush_pipline,
  input  logic [INS_W-1:0]       flush_pc,
  output logic                   try_start_insfetch_task,
  output logic [INS_W-1:0]       insfetch_addr,
  input  logic                   insfetch_task_accepted,
  input  logic                   insfetch_task_done,
  input  logic [INS_W-1:0]       insfetch_ins_full,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [INS_W-1:0]       out_PC,
  output logic [INS_W-1:0]       out_ins,
  output logic [$clog2(DEPTH):0] queue_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  fsm_state_e       state_q;
  logic             try_start_q;
  logic [INS_W-1:0] fetch_pc_q;
  logic [AW-1:0]    rd_ptr_q, wr_ptr_q;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop, not_empty;
  logic [INS_W-1:0] seq_pc, flush_target;
  fq_entry_t        head;

  assign not_empty    = (count_q != '0);
  assign do_pop       = rdy_in & ~flush_pipline & not_empty & out_ready;
  assign do_push      = rdy_in & ~flush_pipline & (state_q == ST_WAIT) & insfetch_task_done;
  assign flush_target = flush_pc & ~32'h3;

`ifdef INSFQ_JAL_FOLLOW_EN
  assign seq_pc = (insfetch_ins_full[6:0] == OPCODE_JAL) ?
                  jal_target(fetch_pc_q, insfetch_ins_full) : fetch_pc_q + 32'd4;
`else
  assign seq_pc = fetch_pc_q + 32'd4;
`endif

  // Occupancy after this cycle's push/pop.
  // NOTE: every combinational output gets a default first so no path
  // through the block leaves it unassigned (which would infer a latch).
  always_comb begin
    count_d = count_q;
    if (do_push && !do_pop) begin
      count_d = count_q + CW'(1);
    end else if (do_pop && !do_push) begin
      count_d = count_q - CW'(1);
    end
  end

  // Fetch FSM, fetch PC, queue pointers and count; registered request output.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      state_q     <= ST_IDLE;
      try_start_q <= 1'b0;
      fetch_pc_q  <= RESET_PC;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      count_q     <= '0;
    end else if (rdy_in) begin
      if (flush_pipline) begin
        rd_ptr_q   <= '0;
        wr_ptr_q   <= '0;
        count_q    <= '0;
        fetch_pc_q <= flush_target;
        // A word still owed by MemAdapter must be drained before refetching.
        case (state_q)
          ST_REQ: begin
            state_q     <= insfetch_task_accepted ? ST_DRAIN : ST_REQ;
            try_start_q <= ~insfetch_task_accepted;
          end
          ST_WAIT, ST_DRAIN: begin
            state_q     <= insfetch_task_done ? ST_REQ : ST_DRAIN;
            try_start_q <= insfetch_task_done;
          end
          default: begin
            state_q     <= ST_REQ;
            try_start_q <= 1'b1;
          end
        endcase
      end else begin
        if (do_push) begin
          wr_ptr_q   <= wr_ptr_q + AW'(1);
          fetch_pc_q <= seq_pc;
        end
        if (do_pop) begin
          rd_ptr_q <= rd_ptr_q + AW'(1);
        end
        count_q <= count_d;
        case (state_q)
          ST_IDLE: begin
            if (count_q < FULL_CNT) begin
              state_q     <= ST_REQ;
              try_start_q <= 1'b1;
            end
          end
          ST_REQ: begin
            if (insfetch_task_accepted) begin
              state_q     <= ST_WAIT;
              try_start_q <= 1'b0;
            end
          end
          ST_WAIT: begin
            if (insfetch_task_done) begin
              state_q     <= (count_d < FULL_CNT) ? ST_REQ : ST_IDLE;
              try_start_q <= (count_d < FULL_CNT);
            end
          end
          default: begin
            if (insfetch_task_done) begin
              state_q     <= ST_REQ;
              try_start_q <= 1'b1;
            end
          end
        endcase
      end
    end
  end

  insfq_store #(.DEPTH(DEPTH)) u_store (
    .clk_in  (clk_in),
    .we_i    (do_push),
    .waddr_i (wr_ptr_q),
    .wdata_i ('{pc: fetch_pc_q, ins: insfetch_ins_full}),
    .raddr_i (rd_ptr_q),
    .rdata_o (head)
  );

  assign try_start_insfetch_task = try_start_q;
  assign insfetch_addr           = fetch_pc_q;
  assign out_valid               = not_empty;
  assign out_PC                  = not_empty ? head.pc  : '0;
  assign out_ins                 = not_empty ? head.ins : '0;
  assign queue_count             = count_q;

endmodule
